serial_loader: RTL

SERIAL_LOADER -- requirements
Module: serial_loader

---
 rtl/serial_loader_pkg.sv | 22 ++
 rtl/serial_loader_bit_counter.sv | 55 +++++
 rtl/serial_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/serial_loader_pkg.sv
// Shared types and constants for the serial loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package serial_loader_pkg;

    // Loader FSM states; the encodings are fixed so external debug taps
    // can decode them.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_LOAD  = 2'b10
    } state_e;

    localparam int DEFAULT_WIDTH = 16;

    // Bits needed to hold a count that ranges 0..width inclusive.
    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_loader_bit_counter.sv
// Frame bit counter: load-to-1, increment, hold, sync clear, terminal flag.
// Latency: count updates on the clock edge after the request.
// Backpressure: none; the counter holds whenever no request is present.
//
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   clr_i            synchronous clear to 0
//   load1_i          load count=1 (first bit of a frame accepted)
//   inc_i            count one more accepted bit
//   last_o           count == WIDTH-1, i.e. the next accepted bit completes the word
`timescale 1ns/1ps
module bit_counter
    import serial_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic load1_i,
    input  logic inc_i,
    output logic last_o
);

    localparam int CW = cnt_bits(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = CW'(1);
        end else if (inc_i && (cnt_q < CW'(WIDTH))) begin
            // Saturate at WIDTH so a stray increment can never overrun.
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CW'(WIDTH - 1));

    cnt_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CW'(WIDTH));

endmodule

// File: rtl/serial_loader.sv
// Serial-to-parallel loader: assembles WIDTH framed serial bits into D and
// strobes CE for one cycle so a downstream register captures the word.
// Latency: CE and the new D appear the cycle after the WIDTH-th bit is accepted.
// Backpressure: none; SVALID gaps simply stall assembly with no timeout.
//
// Ports:
//   CLK, CLR_N        clock, async active-low reset
//   SIN, SVALID       serial bit and its qualifier (one bit per valid cycle)
//   SSTART            marks the first bit of a frame (only meaningful with SVALID)
//   ERR_CLR           synchronous clear of the sticky error flag
//   D, CE             assembled word and one-cycle load strobe
//   BUSY, ERR         FSM not idle; sticky framing error
`timescale 1ns/1ps
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             SIN,
    input  logic             SVALID,
    input  logic             SSTART,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] D,
    output logic             CE,
    output logic             BUSY,
    output logic             ERR
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] sr_first;
    logic [WIDTH-1:0] d_q;
    logic             ce_q;
    logic             busy_q;
    logic             err_q;
    logic             err_evt;
    logic             cnt_clr;
    logic             cnt_load1;
    logic             cnt_inc;
    logic             cnt_last;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk_i   (CLK),
        .rst_ni  (CLR_N),
        .clr_i   (cnt_clr),
        .load1_i (cnt_load1),
        .inc_i   (cnt_inc),
        .last_o  (cnt_last)
    );

    // Bit ordering: MSB-first shifts left so the first bit ends in D[WIDTH-1];
    // LSB-first shifts right so the first bit ends in D[0]. Starting a frame
    // places SIN where a shift-in would, discarding any partial word.
    always_comb begin
        if (MSB_FIRST) begin
            sr_shift = {sr_q[WIDTH-2:0], SIN};
            sr_first = {{(WIDTH-1){1'b0}}, SIN};
        end else begin
            sr_shift = {SIN, sr_q[WIDTH-1:1]};
            sr_first = {SIN, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        err_evt   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (SVALID) begin
                    if (SSTART) begin
                        sr_d      = sr_first;
                        cnt_load1 = 1'b1;
                        state_d   = ST_SHIFT;
                    end else begin
                        // Data without a frame start is dropped.
                        err_evt = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (SVALID) begin
                    if (SSTART) begin
                        // Premature start: flag it and restart the frame.
                        err_evt   = 1'b1;
                        sr_d      = sr_first;
                        cnt_load1 = 1'b1;
                    end else begin
                        sr_d    = sr_shift;
                        cnt_inc = 1'b1;
                        if (cnt_last) begin
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (SVALID && SSTART) begin
                    // Back-to-back frame: this bit is bit 1 of the next word.
                    sr_d      = sr_first;
                    cnt_load1 = 1'b1;
                    state_d   = ST_SHIFT;
                end else begin
                    err_evt = SVALID;
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so CE and BUSY line up
    // exactly with the state they describe.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            d_q     <= '0;
            ce_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            ce_q    <= (state_d == ST_LOAD);
            busy_q  <= (state_d != ST_IDLE);
            // A new error wins over a simultaneous clear.
            err_q   <= (err_q & ~ERR_CLR) | err_evt;
            if (state_d == ST_LOAD) begin
                d_q <= sr_d;
            end
        end
    end

    assign D    = d_q;
    assign CE   = ce_q;
    assign BUSY = busy_q;
    assign ERR  = err_q;

    ce_single_cycle: assert property (@(posedge CLK) disable iff (!CLR_N)
        CE |=> !CE);

endmodule
